// File: rtl/sdram_refresh_req_gen.sv
// sdram_refresh_req_gen
//   Periodic auto-refresh request generator for the AXI SDRAM controller.
//   An interval timer earns one refresh credit every REF_ITV cycles. Owed
//   refreshes are offered to the command arbiter over valid/ready. Each
//   accepted request is followed by an RFC_CYC-cycle recovery gap.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   en             in   refresh timing enable
//   ref_req_valid  out  refresh request to arbiter
//   ref_req_ready  in   arbiter accepts request (handshake = valid & ready)
//   ref_urgent     out  pending >= URGENT_TH
//   pending_cnt    out  owed refreshes
//   overflow_err   out  sticky, a credit was lost at saturation
//   stats_clr      in   clear ref_issued_cnt        (SDRAM_REF_STATS_EN only)
//   ref_issued_cnt out  saturating handshake count  (SDRAM_REF_STATS_EN only)
//
// Build option: define SDRAM_REF_STATS_EN to add the handshake statistics.
//
// State   | meaning
// --------+---------------------------------------------------------
// IDLE    | nothing owed or timing disabled, valid low
// REQ     | refresh offered to arbiter, valid high
// RECOVER | post-refresh gap, valid low, rfc_cnt counting down

module sdram_refresh_req_gen #(
    parameter int REF_ITV     = 1560,
    parameter int MAX_PENDING = 8,
    parameter int URGENT_TH   = 6,
    parameter int RFC_CYC     = 7
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    output logic                               ref_req_valid,
    input  logic                               ref_req_ready,
    output logic                               ref_urgent,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt,
    output logic                               overflow_err
`ifdef SDRAM_REF_STATS_EN
    ,
    input  logic                               stats_clr,
    output logic [15:0]                        ref_issued_cnt
`endif
);

    localparam int PW       = $clog2(MAX_PENDING + 1);
    localparam int ITV_W    = $clog2(REF_ITV);
    localparam int RFC_W    = (RFC_CYC > 1) ? $clog2(RFC_CYC) : 1;
    localparam int RFC_LOAD = (RFC_CYC > 0) ? RFC_CYC - 1 : 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t           state;
    logic [ITV_W-1:0] itv_cnt;
    logic [RFC_W-1:0] rfc_cnt;
    logic [PW-1:0]    pending;
    logic             tick;
    logic             hs;

    assign tick = en && (itv_cnt == '0);
    assign hs   = (state == REQ) && ref_req_ready;

    // Interval timer: held at reload value while disabled so the first
    // credit after enabling always takes a full interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            itv_cnt <= ITV_W'(REF_ITV - 1);
        end else if (!en || itv_cnt == '0) begin
            itv_cnt <= ITV_W'(REF_ITV - 1);
        end else begin
            itv_cnt <= itv_cnt - 1'b1;
        end
    end

    // Owed-refresh counter; a simultaneous credit and handshake cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (tick && !hs) begin
                if (pending == PW'(MAX_PENDING)) begin
                    overflow_err <= 1'b1;
                end else begin
                    pending <= pending + 1'b1;
                end
            end else if (hs && !tick) begin
                pending <= pending - 1'b1;
            end
        end
    end

    // A handshake takes priority over en falling so the recovery gap is
    // always honoured once the arbiter has issued the refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rfc_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending != '0 && en) state <= REQ;
                end
                REQ: begin
                    if (hs) begin
                        if (RFC_CYC > 0) begin
                            state   <= RECOVER;
                            rfc_cnt <= RFC_W'(RFC_LOAD);
                        end else if ((pending > PW'(1) || tick) && en) begin
                            state <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!en) begin
                        state <= IDLE;
                    end
                end
                RECOVER: begin
                    if (rfc_cnt == '0) begin
                        state <= (pending != '0 && en) ? REQ : IDLE;
                    end else begin
                        rfc_cnt <= rfc_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ref_req_valid = (state == REQ);
    assign ref_urgent    = (pending >= PW'(URGENT_TH));
    assign pending_cnt   = pending;

`ifdef SDRAM_REF_STATS_EN
    // A handshake coinciding with a clear counts as the first new event.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_issued_cnt <= '0;
        end else if (hs) begin
            if (stats_clr) begin
                ref_issued_cnt <= 16'd1;
            end else if (ref_issued_cnt != 16'hFFFF) begin
                ref_issued_cnt <= ref_issued_cnt + 16'd1;
            end
        end else if (stats_clr) begin
            ref_issued_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_refresh_req_gen.sv
// tb_sdram_refresh_req_gen
//   Directed bench for sdram_refresh_req_gen with REF_ITV=16, MAX_PENDING=8,
//   URGENT_TH=6, RFC_CYC=3. cyc counts rising edges from the first edge at
//   which en is sampled high (that edge is cyc 0); checks are made 1 time
//   unit after the edge named.

module tb_sdram_refresh_req_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ref_req_valid;
    logic       ref_req_ready;
    logic       ref_urgent;
    logic [3:0] pending_cnt;
    logic       overflow_err;
`ifdef SDRAM_REF_STATS_EN
    logic        stats_clr;
    logic [15:0] ref_issued_cnt;
`endif

    int n_cmp;
    int n_bad;
    int cyc;

    sdram_refresh_req_gen #(
        .REF_ITV     (16),
        .MAX_PENDING (8),
        .URGENT_TH   (6),
        .RFC_CYC     (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .ref_req_valid  (ref_req_valid),
        .ref_req_ready  (ref_req_ready),
        .ref_urgent     (ref_urgent),
        .pending_cnt    (pending_cnt),
        .overflow_err   (overflow_err)
`ifdef SDRAM_REF_STATS_EN
        ,
        .stats_clr      (stats_clr),
        .ref_issued_cnt (ref_issued_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        ref_req_ready = 1'b0;
`ifdef SDRAM_REF_STATS_EN
        stats_clr = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;

        chk("rst_valid",   32'(ref_req_valid), 0);
        chk("rst_pending", 32'(pending_cnt),   0);
        chk("rst_urgent",  32'(ref_urgent),    0);
        chk("rst_ovf",     32'(overflow_err),  0);
`ifdef SDRAM_REF_STATS_EN
        chk("rst_issued",  32'(ref_issued_cnt), 0);
`endif

        // Timer must not run while disabled.
        repeat (40) step();
        chk("dis_pending", 32'(pending_cnt),   0);
        chk("dis_valid",   32'(ref_req_valid), 0);

        // Free-running refresh with an always-ready arbiter.
        en = 1'b1;
        ref_req_ready = 1'b1;
        cyc = -1;
        goto(14);  chk("t1_pend14",   32'(pending_cnt),   0);
        goto(15);  chk("t1_pend15",   32'(pending_cnt),   1);
                   chk("t1_valid15",  32'(ref_req_valid), 0);
        goto(16);  chk("t1_valid16",  32'(ref_req_valid), 1);
        goto(17);  chk("t1_valid17",  32'(ref_req_valid), 0);
                   chk("t1_pend17",   32'(pending_cnt),   0);
        goto(31);  chk("t1_valid31",  32'(ref_req_valid), 0);
        goto(32);  chk("t1_valid32",  32'(ref_req_valid), 1);
        goto(33);  chk("t1_valid33",  32'(ref_req_valid), 0);
                   chk("t1_pend33",   32'(pending_cnt),   0);

        // Arbiter stalls: credits pile up to urgency and overflow.
        ref_req_ready = 1'b0;
        goto(48);  chk("t2_valid48",  32'(ref_req_valid), 1);
        goto(126); chk("t2_pend126",  32'(pending_cnt),   5);
                   chk("t2_urg126",   32'(ref_urgent),    0);
        goto(127); chk("t2_pend127",  32'(pending_cnt),   6);
                   chk("t2_urg127",   32'(ref_urgent),    1);
        goto(159); chk("t2_pend159",  32'(pending_cnt),   8);
                   chk("t2_ovf159",   32'(overflow_err),  0);
        goto(174); chk("t2_ovf174",   32'(overflow_err),  0);
        goto(175); chk("t2_pend175",  32'(pending_cnt),   8);
                   chk("t2_ovf175",   32'(overflow_err),  1);
                   chk("t2_valid175", 32'(ref_req_valid), 1);

        // Drain at one handshake per 4 cycles.
        ref_req_ready = 1'b1;
        goto(176); chk("t3_pend176",  32'(pending_cnt),   7);
                   chk("t3_valid176", 32'(ref_req_valid), 0);
        goto(178); chk("t3_valid178", 32'(ref_req_valid), 0);
        goto(179); chk("t3_valid179", 32'(ref_req_valid), 1);
        goto(183); chk("t3_pend183",  32'(pending_cnt),   6);
                   chk("t3_urg183",   32'(ref_urgent),    1);
        goto(184); chk("t3_pend184",  32'(pending_cnt),   5);
                   chk("t3_urg184",   32'(ref_urgent),    0);
        goto(191); chk("t3_pend191",  32'(pending_cnt),   5);
                   chk("t3_valid191", 32'(ref_req_valid), 1);
        goto(212); chk("t3_pend212",  32'(pending_cnt),   0);
        goto(215); chk("t3_valid215", 32'(ref_req_valid), 0);
        goto(223); chk("t3_pend223",  32'(pending_cnt),   1);
                   chk("t3_valid223", 32'(ref_req_valid), 0);
        goto(224); chk("t3_valid224", 32'(ref_req_valid), 1);
        goto(225); chk("t3_pend225",  32'(pending_cnt),   0);
                   chk("t3_ovf225",   32'(overflow_err),  1);
`ifdef SDRAM_REF_STATS_EN
                   chk("t3_issued",   32'(ref_issued_cnt), 13);
`endif

        // Handshake coinciding with a credit keeps pending at 1.
        ref_req_ready = 1'b0;
        goto(239); chk("t4_pend239",  32'(pending_cnt),   1);
                   chk("t4_valid239", 32'(ref_req_valid), 0);
        goto(240); chk("t4_valid240", 32'(ref_req_valid), 1);
        goto(254); chk("t4_valid254", 32'(ref_req_valid), 1);
        ref_req_ready = 1'b1;
        goto(255); chk("t4_pend255",  32'(pending_cnt),   1);
                   chk("t4_valid255", 32'(ref_req_valid), 0);
        ref_req_ready = 1'b0;
        goto(257); chk("t4_valid257", 32'(ref_req_valid), 0);
        goto(258); chk("t4_valid258", 32'(ref_req_valid), 1);

        // Disable while requesting, then re-enable.
        en = 1'b0;
        goto(259); chk("t5_valid259", 32'(ref_req_valid), 0);
                   chk("t5_pend259",  32'(pending_cnt),   1);
        goto(269); chk("t5_valid269", 32'(ref_req_valid), 0);
                   chk("t5_pend269",  32'(pending_cnt),   1);
        en = 1'b1;
        goto(270); chk("t5_valid270", 32'(ref_req_valid), 1);
        goto(284); chk("t5_pend284",  32'(pending_cnt),   1);
        goto(285); chk("t5_pend285",  32'(pending_cnt),   2);

        // Reset while in RECOVER with pending=5.
        goto(349); chk("t6_pend349",  32'(pending_cnt),   6);
                   chk("t6_urg349",   32'(ref_urgent),    1);
        ref_req_ready = 1'b1;
        goto(350); chk("t6_pend350",  32'(pending_cnt),   5);
                   chk("t6_valid350", 32'(ref_req_valid), 0);
                   chk("t6_urg350",   32'(ref_urgent),    0);
        ref_req_ready = 1'b0;
        rst = 1'b1;
        goto(351); chk("t6_valid351", 32'(ref_req_valid), 0);
                   chk("t6_pend351",  32'(pending_cnt),   0);
                   chk("t6_urg351",   32'(ref_urgent),    0);
                   chk("t6_ovf351",   32'(overflow_err),  0);
`ifdef SDRAM_REF_STATS_EN
                   chk("t6_issued",   32'(ref_issued_cnt), 0);
`endif
        rst = 1'b0;
        goto(366); chk("t6_pend366",  32'(pending_cnt),   0);
        goto(367); chk("t6_pend367",  32'(pending_cnt),   1);
        goto(368); chk("t6_valid368", 32'(ref_req_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
